serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial N-bit adder controller. It time-shares one instance of the team's `adder_1bit` full-adder cell across WIDTH clock cycles to add two WIDTH-bit operands, least significant bit first. It provides a start/done handshake and a registered result. It sits between a requesting datapath (or test driver) and the single 1-bit adder cell, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on rising edge only when busy=0.
- a  in  WIDTH  operand A; latched on the accepting edge.
- b  in  WIDTH  operand B; latched on the accepting edge.
- carry_in  in  1  initial carry; latched on the accepting edge.
- busy  out  1  high while the add sequence is in progress.
- done  out  1  single-cycle pulse; result valid.
- sum  out  WIDTH  registered result; held until next completion.
- carry_out  out  1  carry out of MSB; held with sum.
- overflow  out  1  signed overflow (carry into MSB XOR carry out of MSB); held with sum.

## Operation
- Internal state: operand shift registers opa/opb (WIDTH each), partial-sum shift register psum (WIDTH), carry flop c, bit counter cnt ($clog2(WIDTH) bits), carry-into-MSB flop cmsb.
- Single `adder_1bit` instance: inputs opa[0], opb[0], c; outputs s, co.
- FSM states:
  - IDLE: busy=0, done=0. If start=1 → load opa=a, opb=b, c=carry_in, cnt=0; go to ADD.
  - ADD: busy=1. Each edge: psum shifts right with s into psum[WIDTH-1]; opa/opb shift right; c←co; cnt←cnt+1.
    - When cnt==WIDTH-1, capture cmsb←c before update.
    - On that same edge: sum←{s, psum[WIDTH-1:1]}, carry_out←co, overflow←c^co; go to DONE.
  - DONE: done=1, busy=0. If start=1 → load as in IDLE and go to ADD (back-to-back); else go to IDLE.
- start while busy=1 is ignored; no queuing.
- Operand inputs may change freely after the accepting edge.
- Arithmetic: {carry_out, sum} == a + b + carry_in, computed modulo 2^(WIDTH+1).
- Reset (asynchronous assertion, any state, including mid-ADD): state=IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0; all internal registers 0. The in-flight operation is discarded with no done pulse.
- All outputs are registered; no combinational input-to-output path.

## Timing
- Accepting edge E0 (start=1, busy=0).
- busy=1 from E0 to E0+WIDTH.
- sum, carry_out and overflow update at E0+WIDTH.
- done=1 for exactly one cycle, E0+WIDTH to E0+WIDTH+1.
- Latency WIDTH+1 cycles from the accepting edge to the end of done. Maximum throughput is one add per WIDTH+1 cycles, using start asserted during DONE.
- Results stay stable from one done until the next completion edge. They do not change while the next add is in progress.
- Reset deassertion takes effect synchronously; the first start is accepted on the first rising edge with n_rst=1.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start → busy high 8 cycles, done pulse at E0+8, sum=0x96, carry_out=0, overflow=1.
- a=0xFF, b=0x01, cin=0 → sum=0x00, carry_out=1, overflow=0. Then a=0x80, b=0x80, cin=1 → sum=0x01, carry_out=1, overflow=1.
- Hold start=1 continuously with 0x01+0x01, then 0x7F+0x00 presented after the first acceptance → accepts at E0 and E0+9 only; done at E0+8 (sum=0x02) and E0+17 (sum=0x7F). The second operand pair is latched at E0+9.
- Pulse start again at E0+3 with different operands → ignored; result unchanged; exactly one done pulse.
- Assert n_rst=0 at E0+4 mid-ADD → busy/done/sum/carry_out/overflow=0 immediately; no done pulse. After release, a new 0x10+0x20 add → sum=0x30.
- Random regression, 1000 ops, WIDTH=8 and WIDTH=16 → {carry_out, sum} equals the reference sum every op; done width always one cycle.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that reuses one full-adder cell over WIDTH cycles
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, psum_q, psum_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, co_q, co_d, ov_q, ov_d;
  logic s, co, load, adding, fin;
  adder_1bit u_fa (.a(opa_q[0]), .b(opb_q[0]), .cin(c_q), .s(s), .co(co));
  // state and datapath registers; reset discards any in-flight add
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end
  // next state: accept in IDLE/DONE, shift one bit per ADD cycle, publish on the last bit
  always_comb begin
    adding  = state_q == ADD;
    load    = start && !adding;
    fin     = adding && (cnt_q == CW'(WIDTH-1));
    state_d = load ? ADD : !adding ? IDLE : fin ? DONE : ADD;
    opa_d   = load ? a : adding ? opa_q >> 1 : opa_q;
    opb_d   = load ? b : adding ? opb_q >> 1 : opb_q;
    c_d     = load ? carry_in : adding ? co : c_q;
    cnt_d   = load ? '0 : adding ? cnt_q + 1'b1 : cnt_q;
    psum_d  = adding ? {s, psum_q[WIDTH-1:1]} : psum_q;
    sum_d   = fin ? {s, psum_q[WIDTH-1:1]} : sum_q;
    co_d    = fin ? co : co_q;
    ov_d    = fin ? c_q ^ co : ov_q;
  end
  assign busy      = state_q == ADD;
  assign done      = state_q == DONE;
  assign sum       = sum_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
endmodule
